pe_spad_loader: RTL and testbench

- Write-side companion of the PE controller. It fills the filter and ifmap scratchpads from the PE's input FIFOs, then feeds the ifmap shift chain during strides.
- It prefetches the ifmap words needed for each stride into a local buffer. It raises stall toward the controller until the data for the next step is in place.
- It tracks the n-pass loop so that each ifmap reload is aligned with the controller's reset_ifmap_spad strobe.

---
 rtl/pe_spad_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_pe_spad_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_spad_loader.sv
// pe_spad_loader: fills the PE filter and ifmap scratchpads from their input
// FIFOs, then prefetches the refill words of every pass into a local buffer
// that feeds the ifmap shift chain. stall holds the controller until the next
// stride is buffered.
module pe_spad_loader #(
    parameter int DATA_WIDTH        = 16,
    parameter int S_WIDTH           = 4,
    parameter int F_WIDTH           = 6,
    parameter int U_WIDTH           = 3,
    parameter int n_WIDTH           = 3,
    parameter int p_WIDTH           = 5,
    parameter int q_WIDTH           = 3,
    parameter int IFMAP_ADDR_WIDTH  = 4,
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int BUF_DEPTH         = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic [S_WIDTH-1:0]           S,
    input  logic [F_WIDTH-1:0]           F,
    input  logic [U_WIDTH-1:0]           U,
    input  logic [n_WIDTH-1:0]           n,
    input  logic [p_WIDTH-1:0]           p,
    input  logic [q_WIDTH-1:0]           q,
    input  logic                         filter_fifo_empty,
    input  logic [DATA_WIDTH-1:0]        filter_fifo_dout,
    output logic                         filter_fifo_rd_en,
    input  logic                         ifmap_fifo_empty,
    input  logic [DATA_WIDTH-1:0]        ifmap_fifo_dout,
    output logic                         ifmap_fifo_rd_en,
    output logic                         filter_spad_we,
    output logic [FILTER_ADDR_WIDTH-1:0] filter_spad_addr,
    output logic [DATA_WIDTH-1:0]        filter_spad_wdata,
    output logic                         ifmap_spad_we,
    output logic [IFMAP_ADDR_WIDTH-1:0]  ifmap_spad_addr,
    output logic [DATA_WIDTH-1:0]        ifmap_spad_wdata,
    input  logic                         shift,
    output logic [DATA_WIDTH-1:0]        shift_data,
    input  logic                         reset_ifmap_spad,
    output logic                         stall,
    output logic                         underflow
);
    localparam int BUF_AW    = $clog2(BUF_DEPTH);
    localparam int BUF_CNT_W = BUF_AW + 1;
    localparam int NF_W      = S_WIDTH + q_WIDTH + p_WIDTH;
    localparam int NI_W      = S_WIDTH + q_WIDTH;
    localparam int NR_W      = U_WIDTH + q_WIDTH;
    localparam int FC_W      = F_WIDTH + U_WIDTH + q_WIDTH;
    localparam int SUM_W     = ((BUF_CNT_W > NR_W) ? BUF_CNT_W : NR_W) + 1;

    typedef enum logic [1:0] {IDLE, LOAD_FILTER, LOAD_IFMAP, RUN} state_t;

    state_t                 state_reg;
    logic [S_WIDTH-1:0]     s_reg;
    logic [F_WIDTH-1:0]     f_reg;
    logic [U_WIDTH-1:0]     u_reg;
    logic [n_WIDTH-1:0]     n_reg;
    logic [p_WIDTH-1:0]     p_reg;
    logic [q_WIDTH-1:0]     q_reg;
    logic [n_WIDTH-1:0]     pass_cnt_reg;
    logic [NF_W-1:0]        fcnt_reg;
    logic [NI_W-1:0]        icnt_reg;
    logic [FC_W-1:0]        fetch_cnt_reg;
    logic [NR_W-1:0]        shift_cnt_reg;
    logic [BUF_AW-1:0]      wr_ptr_reg;
    logic [BUF_AW-1:0]      rd_ptr_reg;
    logic [BUF_CNT_W-1:0]   buf_cnt_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   underflow_reg;
    logic [DATA_WIDTH-1:0]  buf_mem [BUF_DEPTH];

    // Loop bounds derived from the latched configuration.
    logic [NF_W-1:0]    nf;
    logic [NI_W-1:0]    ni;
    logic [NR_W-1:0]    nr;
    logic [F_WIDTH-1:0] f_minus_1;
    logic [FC_W-1:0]    nt;
    assign nf        = NF_W'(s_reg) * NF_W'(q_reg) * NF_W'(p_reg);
    assign ni        = NI_W'(s_reg) * NI_W'(q_reg);
    assign nr        = NR_W'(u_reg) * NR_W'(q_reg);
    assign f_minus_1 = f_reg - F_WIDTH'(1);
    assign nt        = FC_W'(f_minus_1) * FC_W'(nr);

    logic filt_take, ifm_take, buf_empty, fetch_pending, prefetch;
    logic shift_pop, shift_uflow, stall_run;
    logic [SUM_W-1:0] staged_words;

    assign filt_take     = (state_reg == LOAD_FILTER) && !filter_fifo_empty;
    assign ifm_take      = (state_reg == LOAD_IFMAP) && !ifmap_fifo_empty;
    assign buf_empty     = (buf_cnt_reg == '0);
    assign fetch_pending = (fetch_cnt_reg < nt);
    assign prefetch      = (state_reg == RUN) && fetch_pending &&
                           (buf_cnt_reg < BUF_CNT_W'(BUF_DEPTH)) && !ifmap_fifo_empty;
    assign shift_pop     = (state_reg == RUN) && shift && !buf_empty;
    assign shift_uflow   = (state_reg == RUN) && shift && buf_empty;
    // Words of the current stride already consumed plus words waiting in the buffer.
    assign staged_words  = SUM_W'(buf_cnt_reg) + SUM_W'(shift_cnt_reg);
    assign stall_run     = fetch_pending && (staged_words < SUM_W'(nr));

    assign filter_fifo_rd_en = filt_take;
    assign filter_spad_we    = filt_take;
    assign filter_spad_addr  = fcnt_reg[FILTER_ADDR_WIDTH-1:0];
    assign filter_spad_wdata = filter_fifo_dout;
    assign ifmap_fifo_rd_en  = ifm_take || prefetch;
    assign ifmap_spad_we     = ifm_take;
    assign ifmap_spad_addr   = icnt_reg[IFMAP_ADDR_WIDTH-1:0];
    assign ifmap_spad_wdata  = ifmap_fifo_dout;
    assign shift_data        = buf_empty ? '0 : buf_mem[rd_ptr_reg];
    assign stall             = (state_reg == LOAD_FILTER) || (state_reg == LOAD_IFMAP) ||
                               ((state_reg == RUN) && stall_run);
    assign busy              = busy_reg;
    assign done              = done_reg;
    assign underflow         = underflow_reg;

    // Prefetch buffer storage: push at the tail pointer.
    always_ff @(posedge clk) begin
        if (prefetch) begin
            buf_mem[wr_ptr_reg] <= ifmap_fifo_dout;
        end
    end

    // Job sequencer: load filters once, then per pass load the ifmap window and stream refills.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            f_reg         <= '0;
            u_reg         <= '0;
            n_reg         <= '0;
            p_reg         <= '0;
            q_reg         <= '0;
            pass_cnt_reg  <= '0;
            fcnt_reg      <= '0;
            icnt_reg      <= '0;
            fetch_cnt_reg <= '0;
            shift_cnt_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            buf_cnt_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (shift_uflow) begin
                underflow_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        s_reg        <= S;
                        f_reg        <= F;
                        u_reg        <= U;
                        n_reg        <= n;
                        p_reg        <= p;
                        q_reg        <= q;
                        pass_cnt_reg <= '0;
                        fcnt_reg     <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= LOAD_FILTER;
                    end
                end
                LOAD_FILTER: begin
                    if (filt_take) begin
                        if (fcnt_reg == nf - NF_W'(1)) begin
                            fcnt_reg  <= '0;
                            icnt_reg  <= '0;
                            state_reg <= LOAD_IFMAP;
                        end else begin
                            fcnt_reg <= fcnt_reg + NF_W'(1);
                        end
                    end
                end
                LOAD_IFMAP: begin
                    if (ifm_take) begin
                        if (icnt_reg == ni - NI_W'(1)) begin
                            icnt_reg      <= '0;
                            fetch_cnt_reg <= '0;
                            shift_cnt_reg <= '0;
                            wr_ptr_reg    <= '0;
                            rd_ptr_reg    <= '0;
                            buf_cnt_reg   <= '0;
                            state_reg     <= RUN;
                        end else begin
                            icnt_reg <= icnt_reg + NI_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (prefetch) begin
                        wr_ptr_reg    <= wr_ptr_reg + BUF_AW'(1);
                        fetch_cnt_reg <= fetch_cnt_reg + FC_W'(1);
                    end
                    if (shift_pop) begin
                        rd_ptr_reg    <= rd_ptr_reg + BUF_AW'(1);
                        shift_cnt_reg <= (shift_cnt_reg == nr - NR_W'(1)) ? '0
                                                                          : shift_cnt_reg + NR_W'(1);
                    end
                    if (prefetch && !shift_pop) begin
                        buf_cnt_reg <= buf_cnt_reg + BUF_CNT_W'(1);
                    end else if (!prefetch && shift_pop) begin
                        buf_cnt_reg <= buf_cnt_reg - BUF_CNT_W'(1);
                    end
                    // End of pass: leftover buffered words belong to the old window.
                    if (reset_ifmap_spad) begin
                        buf_cnt_reg <= '0;
                        wr_ptr_reg  <= '0;
                        rd_ptr_reg  <= '0;
                        if (pass_cnt_reg == n_reg - n_WIDTH'(1)) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            pass_cnt_reg <= pass_cnt_reg + n_WIDTH'(1);
                            icnt_reg     <= '0;
                            state_reg    <= LOAD_IFMAP;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_spad_loader.sv
// Testbench for pe_spad_loader: bench-owned FIFOs feed the DUT, and a
// job-level reference model (word counts and a queue for the prefetch buffer)
// predicts every output each cycle.
module tb_pe_spad_loader;
    localparam int DW    = 16;
    localparam int LIMIT = 20000;

    logic          clk = 1'b0;
    logic          reset, start, shift, reset_ifmap_spad;
    logic          busy, done, stall, underflow;
    logic [3:0]    S;
    logic [5:0]    F;
    logic [2:0]    U, n, q;
    logic [4:0]    p;
    logic          filter_fifo_empty, filter_fifo_rd_en;
    logic [DW-1:0] filter_fifo_dout;
    logic          ifmap_fifo_empty, ifmap_fifo_rd_en;
    logic [DW-1:0] ifmap_fifo_dout;
    logic          filter_spad_we, ifmap_spad_we;
    logic [7:0]    filter_spad_addr;
    logic [3:0]    ifmap_spad_addr;
    logic [DW-1:0] filter_spad_wdata, ifmap_spad_wdata, shift_data;

    always #5 clk = ~clk;

    pe_spad_loader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .S(S), .F(F), .U(U), .n(n), .p(p), .q(q),
        .filter_fifo_empty(filter_fifo_empty), .filter_fifo_dout(filter_fifo_dout),
        .filter_fifo_rd_en(filter_fifo_rd_en),
        .ifmap_fifo_empty(ifmap_fifo_empty), .ifmap_fifo_dout(ifmap_fifo_dout),
        .ifmap_fifo_rd_en(ifmap_fifo_rd_en),
        .filter_spad_we(filter_spad_we), .filter_spad_addr(filter_spad_addr),
        .filter_spad_wdata(filter_spad_wdata),
        .ifmap_spad_we(ifmap_spad_we), .ifmap_spad_addr(ifmap_spad_addr),
        .ifmap_spad_wdata(ifmap_spad_wdata),
        .shift(shift), .shift_data(shift_data), .reset_ifmap_spad(reset_ifmap_spad),
        .stall(stall), .underflow(underflow)
    );

    int checks = 0;
    int errors = 0;

    // Bench FIFOs (first-word-fall-through) with optional forced-empty gaps.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] iq[$];
    bit f_gap = 0, i_gap = 0;

    // Reference model: phase 0 idle, 1 filter load, 2 ifmap load, 3 run.
    int m_phase = 0, m_loaded = 0, m_fetched = 0, m_pass_shifts = 0, m_pass = 0;
    bit m_uflow = 0, m_done = 0;
    logic [DW-1:0] m_buf[$];
    int c_S = 0, c_F = 0, c_U = 0, c_n = 0, c_p = 0, c_q = 0;

    function automatic int m_nf(); return c_S * c_q * c_p; endfunction
    function automatic int m_ni(); return c_S * c_q; endfunction
    function automatic int m_nr(); return c_U * c_q; endfunction
    function automatic int m_nt(); return (c_F - 1) * c_U * c_q; endfunction

    // Next stride fully available (already shifted part of it plus buffered words).
    function automatic bit m_stall();
        if (m_phase == 1 || m_phase == 2) return 1'b1;
        if (m_phase == 3)
            return (m_fetched < m_nt()) && (m_buf.size() + m_pass_shifts % m_nr() < m_nr());
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void drive_fifo();
        filter_fifo_empty = f_gap || (fq.size() == 0);
        filter_fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
        ifmap_fifo_empty  = i_gap || (iq.size() == 0);
        ifmap_fifo_dout   = (iq.size() != 0) ? iq[0] : '0;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, then pop FIFOs.
    task automatic tick();
        bit f_take, i_load, i_pre, pop_f, pop_i;
        drive_fifo();
        @(negedge clk);
        f_take = (m_phase == 1) && !filter_fifo_empty;
        i_load = (m_phase == 2) && !ifmap_fifo_empty;
        i_pre  = (m_phase == 3) && (m_fetched < m_nt()) && (m_buf.size() < 64) && !ifmap_fifo_empty;
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_done);
        chk("stall", stall, m_stall());
        chk("underflow", underflow, m_uflow);
        chk("filter_rd_en", filter_fifo_rd_en, f_take);
        chk("filter_we", filter_spad_we, f_take);
        chk("ifmap_rd_en", ifmap_fifo_rd_en, i_load || i_pre);
        chk("ifmap_we", ifmap_spad_we, i_load);
        chk("shift_data", shift_data, (m_buf.size() != 0) ? m_buf[0] : 16'h0);
        if (f_take) begin
            chk("filter_addr", filter_spad_addr, m_loaded % 256);
            chk("filter_wdata", filter_spad_wdata, fq[0]);
        end
        if (i_load) begin
            chk("ifmap_addr", ifmap_spad_addr, m_loaded % 16);
            chk("ifmap_wdata", ifmap_spad_wdata, iq[0]);
        end
        pop_f = filter_fifo_rd_en;
        pop_i = ifmap_fifo_rd_en;
        m_done = 0;
        if (reset) begin
            m_phase = 0; m_loaded = 0; m_uflow = 0; m_buf.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    c_S = S; c_F = F; c_U = U; c_n = n; c_p = p; c_q = q;
                    m_pass = 0; m_loaded = 0; m_phase = 1;
                end
                1: if (f_take) begin
                    m_loaded++;
                    if (m_loaded == m_nf()) begin m_loaded = 0; m_phase = 2; end
                end
                2: if (i_load) begin
                    m_loaded++;
                    if (m_loaded == m_ni()) begin
                        m_loaded = 0; m_phase = 3; m_fetched = 0; m_pass_shifts = 0; m_buf.delete();
                    end
                end
                default: begin
                    if (shift) begin
                        if (m_buf.size() == 0) m_uflow = 1;
                        else begin void'(m_buf.pop_front()); m_pass_shifts++; end
                    end
                    if (i_pre) begin m_buf.push_back(ifmap_fifo_dout); m_fetched++; end
                    if (reset_ifmap_spad) begin
                        m_buf.delete();
                        if (m_pass == c_n - 1) begin m_done = 1; m_phase = 0; end
                        else begin m_pass++; m_phase = 2; m_loaded = 0; end
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        if (pop_f && fq.size() != 0) void'(fq.pop_front());
        if (pop_i && iq.size() != 0) void'(iq.pop_front());
    endtask

    task automatic set_cfg(input int s_v, f_v, u_v, n_v, p_v, q_v);
        S = 4'(s_v); F = 6'(f_v); U = 3'(u_v); n = 3'(n_v); p = 5'(p_v); q = 3'(q_v);
    endtask

    task automatic fill_fifos(input int s_v, f_v, u_v, n_v, p_v, q_v, input bit seq);
        int k = 0;
        for (int i = 0; i < s_v * q_v * p_v; i++) fq.push_back(seq ? 16'(i) : 16'($urandom));
        for (int ps = 0; ps < n_v; ps++)
            for (int i = 0; i < s_v * q_v + (f_v - 1) * u_v * q_v; i++) begin
                iq.push_back(seq ? 16'(100 + k) : 16'($urandom));
                k++;
            end
    endtask

    task automatic bounded_fail(input string tag, input int cycles);
        checks++;
        assert (cycles < LIMIT) else begin
            errors++;
            $error("FAIL %s: observed %0d cycles required < %0d", tag, cycles, LIMIT);
        end
    endtask

    // Full job: random shifts only when the next stride is ready; end each pass after all refills shifted.
    task automatic run_job(input int s_v, f_v, u_v, n_v, p_v, q_v,
                           input int gap_pct, input int shift_pct, input bit seq, input bit alt_gap);
        int budget = 0;
        set_cfg(s_v, f_v, u_v, n_v, p_v, q_v);
        fill_fifos(s_v, f_v, u_v, n_v, p_v, q_v, seq);
        start = 1; tick(); start = 0;
        while (m_phase != 0 && budget < LIMIT) begin
            f_gap = alt_gap ? ~f_gap : ($urandom_range(99) < gap_pct);
            i_gap = alt_gap ? 1'b0 : ($urandom_range(99) < gap_pct);
            shift = 0; reset_ifmap_spad = 0;
            if (m_phase == 3) begin
                if (m_pass_shifts == m_nt()) reset_ifmap_spad = 1;
                else if (!m_stall() && $urandom_range(99) < shift_pct) shift = 1;
            end
            tick();
            budget++;
        end
        shift = 0; reset_ifmap_spad = 0; f_gap = 0; i_gap = 0;
        bounded_fail("job_timeout", budget);
        tick();
        tick();
        chk("filter_fifo_drained", fq.size(), 0);
        chk("ifmap_fifo_drained", iq.size(), 0);
        $display("job S=%0d F=%0d U=%0d n=%0d p=%0d q=%0d cycles=%0d checks=%0d errors=%0d",
                 s_v, f_v, u_v, n_v, p_v, q_v, budget, checks, errors);
    endtask

    task automatic wait_model(input int phase, input int loaded);
        int c = 0;
        while (!(m_phase == phase && m_loaded == loaded) && c < LIMIT) begin tick(); c++; end
        bounded_fail("wait_timeout", c);
    endtask

    initial begin
        reset = 1; start = 0; shift = 0; reset_ifmap_spad = 0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        reset = 0;
        tick();

        // Baseline load with F=1 (no refills), then with filter FIFO gaps every other cycle.
        run_job(3, 1, 1, 1, 4, 1, 0, 0, 1, 0);
        run_job(3, 1, 1, 1, 4, 1, 0, 0, 1, 1);
        // Stride prefetch and shifting, then two passes with reload.
        run_job(3, 3, 1, 1, 1, 2, 0, 50, 1, 0);
        run_job(2, 3, 1, 2, 2, 1, 20, 60, 0, 0);

        // Underflow: shift into an empty buffer in RUN; flag is sticky.
        set_cfg(1, 2, 1, 1, 1, 1);
        fq.push_back(16'h0011);
        iq.push_back(16'h0022);
        start = 1; tick(); start = 0;
        wait_model(3, 0);
        shift = 1; tick(); shift = 0;
        tick();
        chk("underflow_set", underflow, 1);
        iq.push_back(16'h0abc);
        repeat (3) tick();
        shift = 1; tick(); shift = 0;
        reset_ifmap_spad = 1; tick(); reset_ifmap_spad = 0;
        tick();
        chk("underflow_sticky", underflow, 1);
        $display("underflow step: checks=%0d errors=%0d", checks, errors);

        // Abort during filter load after five writes, then restart from address 0.
        set_cfg(3, 1, 1, 1, 4, 1);
        fill_fifos(3, 1, 1, 1, 4, 1, 1);
        start = 1; tick(); start = 0;
        wait_model(1, 5);
        f_gap = 1; reset = 1; tick(); reset = 0; f_gap = 0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_underflow_cleared", underflow, 0);
        fq.delete(); iq.delete();
        $display("abort step: checks=%0d errors=%0d", checks, errors);
        run_job(3, 1, 1, 1, 4, 1, 0, 0, 1, 0);

        // Long pass with rare shifts so the prefetch buffer reaches full depth.
        run_job(1, 40, 2, 1, 1, 2, 0, 10, 0, 0);

        // Randomized configurations and handshake gaps.
        for (int j = 0; j < 15; j++)
            run_job($urandom_range(3, 1), $urandom_range(4, 1), $urandom_range(2, 1),
                    $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(2, 1),
                    $urandom_range(40), $urandom_range(90, 20), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
